// File: rtl/error_metrics_acc.sv
// Error-metrics accumulator for approximate-adder characterisation.
// Compares an accurate and an approximate sum per accepted sample and keeps
// running statistics for one measurement run: sample count, error count,
// saturating sum of error distances and maximum error distance.
//
// Handshake: a pair (acc_sum, apx_sum) is transferred on a rising clk edge
// exactly when in_valid and in_ready are both high; in_ready depends only on
// registered state (high in RUN), never combinationally on in_valid.
module error_metrics_acc #(
  parameter int SUM_W = 17,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] acc_sum,
  input  logic [SUM_W-1:0] apx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [SUM_W-1:0] max_ed,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] target;

  logic [SUM_W-1:0] ed;
  logic             accept;
  logic             last_pair;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_next;

  // Error distance: subtract the smaller operand from the larger so it never wraps.
  always_comb begin
    ed = '0;
    if (acc_sum >= apx_sum) ed = acc_sum - apx_sum;
    else                    ed = apx_sum - acc_sum;
  end

  // Accept qualifier and end-of-run detection for the pair on the bus now.
  always_comb begin
    accept    = (state == RUN) && in_valid;
    last_pair = ((sample_count + CNT_W'(1)) == target);
  end

  // Saturating add: one extra bit catches the carry out, which clamps to all-ones.
  always_comb begin
    sum_ext  = {1'b0, sum_ed} + {{(ACC_W + 1 - SUM_W){1'b0}}, ed};
    sum_next = sum_ext[ACC_W-1:0];
    if (sum_ext[ACC_W]) sum_next = '1;
  end

  // Run-control FSM plus statistic registers; statistics change only on start or accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      target       <= '0;
      sample_count <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target       <= num_samples;
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
            if (num_samples == '0) state <= DONE;
            else                   state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            sample_count <= sample_count + CNT_W'(1);
            if (ed != '0) err_count <= err_count + CNT_W'(1);
            if (ed > max_ed) max_ed <= ed;
            sum_ed <= sum_next;
            if (last_pair) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded straight from the registered state.
  always_comb begin
    busy      = (state == RUN);
    in_ready  = (state == RUN);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_error_metrics_acc.sv
// Bench for error_metrics_acc: a default instance and an ACC_W=18 instance
// share all inputs. Expected run results come from a plain-arithmetic model
// over the presented pairs and are queued at start; a monitor pops them when
// done pulses.
module tb_error_metrics_acc;

  localparam int SUM_W = 17;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int SAT_W = 18;
  localparam int EXP_W = CNT_W + CNT_W + ACC_W + SUM_W;
  localparam int BUDGET = 200;
  localparam int unsigned MAXS = (1 << SUM_W) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic [SUM_W-1:0] acc_sum;
  logic [SUM_W-1:0] apx_sum;

  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_count, err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [SUM_W-1:0] max_ed;
  logic [1:0]       state_dbg;

  logic             in_ready_s, busy_s, done_s;
  logic [CNT_W-1:0] sample_count_s, err_count_s;
  logic [SAT_W-1:0] sum_ed_s;
  logic [SUM_W-1:0] max_ed_s;
  logic [1:0]       state_dbg_s;

  int checks;
  int failures;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_sat_q[$];
  logic [EXP_W-1:0] last_exp;
  logic [EXP_W-1:0] last_exp_s;

  int unsigned pa[32];
  int unsigned pb[32];
  bit          vpat[16];
  int          vlen;

  error_metrics_acc #(.SUM_W(SUM_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .acc_sum(acc_sum), .apx_sum(apx_sum),
    .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
    .sum_ed(sum_ed), .max_ed(max_ed), .state_dbg(state_dbg)
  );

  error_metrics_acc #(.SUM_W(SUM_W), .CNT_W(CNT_W), .ACC_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .acc_sum(acc_sum), .apx_sum(apx_sum),
    .busy(busy_s), .done(done_s), .sample_count(sample_count_s), .err_count(err_count_s),
    .sum_ed(sum_ed_s), .max_ed(max_ed_s), .state_dbg(state_dbg_s)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_stats(input string name, input logic [CNT_W-1:0] sc,
                           input logic [CNT_W-1:0] ec, input logic [ACC_W-1:0] se,
                           input logic [SUM_W-1:0] me, input logic [EXP_W-1:0] e);
    chk({name, "_sample_count"}, 64'(sc), 64'(e[EXP_W-1 -: CNT_W]));
    chk({name, "_err_count"},    64'(ec), 64'(e[EXP_W-CNT_W-1 -: CNT_W]));
    chk({name, "_sum_ed"},       64'(se), 64'(e[SUM_W+ACC_W-1 -: ACC_W]));
    chk({name, "_max_ed"},       64'(me), 64'(e[SUM_W-1:0]));
  endtask

  // Reference: statistics over the first n presented pairs, saturating at 2^aw-1.
  function automatic logic [EXP_W-1:0] model(input int n, input int aw);
    longint unsigned sum, cap, mx, ed;
    int errs;
    sum = 0; mx = 0; errs = 0;
    cap = (64'd1 << aw) - 1;
    for (int i = 0; i < n; i++) begin
      ed = (pa[i] > pb[i]) ? longint'(pa[i] - pb[i]) : longint'(pb[i] - pa[i]);
      if (ed != 0) errs++;
      if (ed > mx) mx = ed;
      sum = (sum + ed > cap) ? cap : sum + ed;
    end
    return {CNT_W'(n), CNT_W'(errs), ACC_W'(sum), SUM_W'(mx)};
  endfunction

  // Monitor: every done pulse retires one queued expectation per instance.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else cmp_stats("run", sample_count, err_count, sum_ed, max_ed, exp_q.pop_front());
      end
      if (done_s) begin
        if (exp_sat_q.size() == 0) chk("unexpected_done_sat", 64'(1), 64'(0));
        else cmp_stats("sat", sample_count_s, err_count_s, ACC_W'(sum_ed_s), max_ed_s,
                       exp_sat_q.pop_front());
      end
    end
  end

  task automatic check_zero(input string name);
    chk({name, "_busy"},     64'({busy, busy_s}), 64'(0));
    chk({name, "_in_ready"}, 64'({in_ready, in_ready_s}), 64'(0));
    chk({name, "_done"},     64'({done, done_s}), 64'(0));
    cmp_stats({name, "_main"}, sample_count, err_count, sum_ed, max_ed, '0);
    cmp_stats({name, "_sat"}, sample_count_s, err_count_s, ACC_W'(sum_ed_s), max_ed_s, '0);
  endtask

  task automatic random_pairs();
    for (int i = 0; i < 32; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      pa[i] = $urandom_range(0, MAXS);
      case (sel)
        0: pb[i] = pa[i];
        1: pb[i] = $urandom_range(0, MAXS);
        default: pb[i] = (pa[i] + $urandom_range(0, 7)) & MAXS;
      endcase
    end
  endtask

  // One measurement run; pairs are taken from pa/pb in order on valid cycles.
  task automatic run_task(input int n, input bit mid_start);
    int acc;
    int cyc;
    bit v;
    // in_valid while idle must not touch anything
    in_valid = 1'b1;
    repeat (2) begin
      acc_sum = SUM_W'($urandom);
      apx_sum = SUM_W'($urandom);
      @(negedge clk);
      chk("idle_ready", 64'({in_ready, in_ready_s}), 64'(0));
      @(posedge clk); #1;
    end
    cmp_stats("idle_hold", sample_count, err_count, sum_ed, max_ed, last_exp);
    cmp_stats("idle_hold_sat", sample_count_s, err_count_s, ACC_W'(sum_ed_s), max_ed_s, last_exp_s);

    last_exp   = model(n, ACC_W);
    last_exp_s = model(n, SAT_W);
    exp_q.push_back(last_exp);
    exp_sat_q.push_back(last_exp_s);

    in_valid = 1'b0;
    start = 1'b1;
    num_samples = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_samples = CNT_W'($urandom);

    acc = 0;
    cyc = 0;
    while (acc < n && cyc < BUDGET) begin
      v = (cyc < vlen) ? vpat[cyc] : 1'b1;
      in_valid = v;
      if (v) begin
        acc_sum = SUM_W'(pa[acc]);
        apx_sum = SUM_W'(pb[acc]);
      end else begin
        acc_sum = SUM_W'($urandom);
        apx_sum = SUM_W'($urandom);
      end
      start = mid_start && (cyc == 1);
      if (start) num_samples = CNT_W'(1);
      @(negedge clk);
      chk("run_ready", 64'({in_ready, in_ready_s, busy, busy_s}), 64'(4'hF));
      @(posedge clk); #1;
      if (v) acc++;
      cyc++;
    end
    if (cyc >= BUDGET) chk("run_timeout", 64'(acc), 64'(n));

    // Still offer data in DONE; none of it may be taken.
    start = 1'b0;
    in_valid = 1'b1;
    acc_sum = SUM_W'(MAXS);
    apx_sum = '0;
    @(negedge clk);
    chk("done_pulse", 64'({done, done_s}), 64'(2'b11));
    chk("done_ready", 64'({in_ready, in_ready_s}), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 64'({done, done_s}), 64'(0));
    chk("no_extra_accept", 64'(sample_count), 64'(n));
    @(posedge clk); #1;
  endtask

  // Reset pulse in the middle of a 5-sample run after 2 accepts.
  task automatic reset_mid_run();
    pa[0] = 10; pb[0] = 3;
    pa[1] = 4;  pb[1] = 9;
    exp_q.delete();
    exp_sat_q.delete();
    start = 1'b1;
    num_samples = CNT_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      acc_sum = SUM_W'(pa[i]);
      apx_sum = SUM_W'(pb[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_count", 64'(sample_count), 64'(2));
    chk("pre_reset_sum", 64'(sum_ed), 64'(12));
    #2 rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    last_exp = '0;
    last_exp_s = '0;
  endtask

  // Stimulus
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    acc_sum = '0;
    apx_sum = '0;
    vlen = 0;
    last_exp = '0;
    last_exp_s = '0;
    #3;
    check_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed four-pair run including the full-range distance
    pa[0] = 100; pb[0] = 100;
    pa[1] = 100; pb[1] = 103;
    pa[2] = 50;  pb[2] = 40;
    pa[3] = 0;   pb[3] = 32'h1FFFF;
    run_task(4, 1'b0);
    chk("directed_sum_ed", 64'(sum_ed), 64'(131084));

    // Zero-length run
    run_task(0, 1'b0);

    // Gapped valid
    random_pairs();
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
    vlen = 6;
    run_task(3, 1'b0);
    vlen = 0;

    // Reset mid-run, then a single-pair run
    reset_mid_run();
    pa[0] = 7; pb[0] = 5;
    run_task(1, 1'b0);
    chk("after_reset_err", 64'(err_count), 64'(1));
    chk("after_reset_sum", 64'(sum_ed), 64'(2));

    // Start ignored while running
    random_pairs();
    run_task(3, 1'b1);

    // Saturation of the narrow accumulator
    for (int i = 0; i < 3; i++) begin
      pa[i] = MAXS;
      pb[i] = 0;
    end
    run_task(3, 1'b0);
    chk("sat_sum_ed", 64'(sum_ed_s), 64'(18'h3FFFF));

    // Random runs
    for (int r = 0; r < 8; r++) begin
      random_pairs();
      vlen = 16;
      for (int i = 0; i < 16; i++) vpat[i] = ($urandom_range(0, 2) != 0);
      run_task($urandom_range(1, 12), ($urandom_range(0, 3) == 0));
    end
    vlen = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size() + exp_sat_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
